// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-and-add multiply-accumulate (A*B + addend)
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_sum;
    logic [WIDTH-1:0]  mplier;
    logic [CW-1:0]     count;
    logic              accept;

    // Single adder: the partial product for the current multiplier LSB.
    always_comb begin
        acc_sum = acc;
        if (mplier[0]) begin
            acc_sum = acc + mcand;
        end
    end

    // DONE accepts a new start directly so back-to-back ops cost WIDTH+1 cycles.
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        product <= acc_sum;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase

            if (accept) begin
                mcand  <= {{WIDTH{1'b0}}, multiplicand};
                mplier <= multiplier;
                acc    <= {{WIDTH{1'b0}}, addend};
                count  <= '0;
                busy   <= 1'b1;
                state  <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic         busy;
    logic         done;
    logic [2*W-1:0] product;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .addend       (c),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] prod;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passed = 0;
    logic        armed = 1'b0;
    logic [15:0] last_prod = '0;
    int          next_free = 0;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    function automatic logic [7:0] r8();
        return 8'($urandom);
    endfunction

    // Monitor: outputs settle after posedge, so sample on the falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic exp_busy;
        if (armed) begin
            exp_busy = (sb.size() > 0) && (cyc < sb[0].due);
            check("busy", int'(busy), int'(exp_busy));
            check("busy_done_exclusive", int'(busy && done), 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.due);
                    check("product", int'(product), int'(e.prod));
                    last_prod = e.prod;
                end
            end else begin
                check("product_hold", int'(product), int'(last_prod));
                if (sb.size() > 0 && cyc >= sb[0].due) begin
                    e = sb.pop_front();
                    check("done_missing", 0, 1);
                    last_prod = e.prod;
                end
            end
        end
    end

    // One clock of stimulus; the model accepts a start only once the previous
    // operation has reached its DONE cycle.
    task automatic step(input logic s, input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        int p;
        @(negedge clk);
        start = s;
        a = x;
        b = y;
        c = z;
        @(posedge clk);
        #1;
        if (s && cyc >= next_free) begin
            p = int'(x) * int'(y) + int'(z);
            sb.push_back('{prod: p[15:0], due: cyc + W});
            next_free = cyc + W + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        last_prod = '0;
        next_free = cyc + 1;
        armed = 1'b1;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_product", int'(product), 0);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) step(1'b0, r8(), r8(), r8());
        step(1'b0, r8(), r8(), r8());
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dividend;
        int q;
        int r;

        do_reset();

        step(1'b1, 8'd7, 8'd5, 8'd3);
        drain();
        check("first_result", int'(product), 38);

        step(1'b1, 8'd255, 8'd255, 8'd255);
        drain();
        check("max_result", int'(product), 65280);
        step(1'b1, 8'd0, 8'd200, 8'd17);
        drain();
        check("zero_mcand", int'(product), 17);

        step(1'b1, 8'd7, 8'd28, 8'd4);
        drain();
        check("divider_200_7", int'(product), 200);

        // Divider round trip across every nonzero divisor.
        for (int d = 1; d < 256; d++) begin
            for (int k = 0; k < 2; k++) begin
                dividend = (k == 0) ? 255 : int'(r8());
                q = dividend / d;
                r = dividend % d;
                step(1'b1, 8'(d), 8'(q), 8'(r));
                repeat (W) step(1'b0, r8(), r8(), r8());
            end
        end
        drain();

        // Start during RUN is ignored and input changes do not leak in.
        step(1'b1, 8'd3, 8'd4, 8'd0);
        step(1'b0, r8(), r8(), r8());
        step(1'b0, r8(), r8(), r8());
        step(1'b1, 8'd9, 8'd9, r8());
        repeat (3) step(1'b0, r8(), r8(), r8());
        drain();
        check("ignored_start", int'(product), 12);

        // Reset mid-run discards the operation.
        step(1'b1, r8(), r8(), r8());
        repeat (4) step(1'b0, r8(), r8(), r8());
        do_reset();
        repeat (12) step(1'b0, r8(), r8(), r8());
        step(1'b1, 8'd11, 8'd13, 8'd2);
        drain();
        check("after_reset", int'(product), 145);

        // Start held high: accepted in DONE cycles every WIDTH+1 clocks.
        repeat (100) step(1'b1, r8(), r8(), r8());
        drain();

        repeat (60) begin
            step(1'b1, r8(), r8(), r8());
            repeat ($urandom_range(0, 12)) step(1'($urandom_range(0, 1)), r8(), r8(), r8());
        end
        drain();

        @(negedge clk);
        start = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential shift-and-add multiply-accumulate that rebuilds a dividend from divider outputs: product = multiplicand * multiplier + addend.
- Paired with the 8-bit restoring divider: feed divisor, quotient and remainder, and the product must equal the original dividend.
- Also serves as a general unsigned multi-cycle multiplier with a start/done handshake.
- One partial-product step per clock keeps the datapath to a single adder.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when not busy
multiplicand  input  WIDTH  unsigned operand A (divisor), captured on accepted start
multiplier  input  WIDTH  unsigned operand B (quotient), captured on accepted start
addend  input  WIDTH  unsigned value added to A*B (remainder), captured on accepted start
busy  output  1  high while computing
done  output  1  one-cycle pulse when product becomes valid
product  output  2*WIDTH  A*B + addend, held until next result

Behaviour:
- Reset (rst high at clock edge, any state): state=IDLE, busy=0, done=0, product=0, internal acc/count/operand registers=0. An in-flight operation is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE: on edge with start=1, capture inputs:
  - mcand = zero-extended multiplicand (2*WIDTH).
  - mplier = multiplier.
  - acc = zero-extended addend.
  - count=0, busy=1, go to RUN.
- IDLE with start=0: stay; outputs unchanged.
- RUN, each edge:
  - If mplier[0]=1, acc = acc + mcand.
  - Then mcand shifts left 1, mplier shifts right 1, count increments.
  - After the WIDTH-th step: product = final acc, busy=0, done=1, go to DONE.
- Latency: start sampled at edge N; product valid and done=1 in the cycle after edge N+WIDTH (8 RUN cycles for WIDTH=8).
- DONE lasts one cycle:
  - done returns to 0 at the next edge.
  - If start=1 in DONE, a new operation is accepted directly (go to RUN, busy=1); otherwise go to IDLE.
  - Back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy=1 (RUN) is ignored. It is not queued, and input changes during RUN do not affect the result.
- Arithmetic:
  - All operations unsigned modulo 2^(2*WIDTH).
  - Maximum result (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W fits, so no overflow flag.
  - The adder is 2*WIDTH bits wide; no carry-out is needed.
- Early termination is not permitted: latency is fixed at WIDTH steps even when multiplier=0.
- product keeps its last value through IDLE and RUN; it updates only at completion or reset.
- done and busy are never high in the same cycle.

Test Plan:
- Reset then start with A=7, B=5, addend=3 -> busy high 8 cycles, then done=1 for exactly 1 cycle, product=0x0026 (38).
- A=255, B=255, addend=255 -> product=0xFF00 (65280), no wrap; then A=0, B=200, addend=17 -> product=0x0011 after same 8-cycle latency.
- Divider round trip: for dividend=200, divisor=7, feed A=7, B=28, addend=4 -> product=0x00C8 (200). Sweep all nonzero divisor/dividend pairs through a reference model -> product equals dividend every time.
- Start at cycle 0 (A=3, B=4, addend=0), then pulse start with A=9, B=9 at cycle 3, and change inputs mid-run -> second start ignored, product=0x000C, single done pulse.
- Reset asserted at RUN cycle 4 -> next cycle busy=0, done=0, product=0, state IDLE. No done follows; a new start after reset completes normally.
- Hold start high continuously -> operations are accepted in DONE cycles, done pulses every 9 cycles, product tracks each captured operand set.
